keccak_word_packer: RTL and testbench
=====================================

Name: keccak_word_packer

Overview:
- Upstream neighbour of the Keccak padding/rate stage.
- Collects a message streamed as 64-bit words into one 576-bit rate block (9 words) and applies Keccak multi-rate padding (pad10*1) on the final word.
- Presents each full block to the downstream permutation/absorb stage through a valid/ack handshake.
- Applies backpressure to the word source while a block is pending.

Parameters:
- WORD_W, 64, data word width in bits (fixed 64; other values unsupported).
- RATE_WORDS, 9, words per rate block (576 / 64).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  64  message word; byte 0 = in_data[63:56].
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  word is the final (partial) word of the message.
- in_bytes  input  3  valid bytes in the final word, 0..7; ignored unless in_last.
- in_ready  output  1  packer accepts a word this cycle.
- out_block  output  576  packed block; word 0 = out_block[575:512], word 8 = out_block[63:0].
- out_valid  output  1  out_block holds a complete block.
- out_last  output  1  the presented block is the final block of the message.
- out_ack  input  1  downstream has consumed out_block.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset (clocked while reset=1):
  - state=FILL, word counter=0, out_block=0, out_valid=0, out_last=0, pad-pending flag=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards any partial or pending block; no block is emitted.
- A word is accepted when in_valid & in_ready. Accepted words shift into the block: word n lands at slot n.
- in_ready = (state==FILL). in_valid while in_ready=0 is ignored; the source must hold the word.
- FILL:
  - Non-last word: store it and increment the counter. At count 9, go to FULL.
  - Last word, store-slot rule:
    - Bytes [0..in_bytes-1] come from in_data.
    - Byte in_bytes = 0x01.
    - Remaining bytes = 0x00.
  - Last word, transition: set the pad-pending flag, increment the counter, then go to PAD. If the counter reaches 9, go directly to FULL with the final-byte OR applied.
- PAD:
  - Insert one zero word per cycle until the counter reaches 9.
  - Then OR 0x80 into byte 7 of word 8 (out_block[7:0]) and go to FULL.
  - If 0x01 and 0x80 land in the same byte (in_bytes=7 in slot 8), the byte is 0x81.
- FULL:
  - out_valid=1; out_last = pad-pending flag.
  - Hold out_block stable until out_ack. Latency: out_valid rises the cycle after the 9th word (or final pad word) is written.
  - On out_ack: out_valid=0 next cycle, counter=0, block cleared, flag cleared, state=FILL.
  - out_ack while out_valid=0 is ignored.
- Message length a multiple of 8 bytes: the source sends every data word with in_last=0, then one extra word with in_last=1, in_bytes=0 (in_data ignored).
  - If that extra word falls at counter 0, it produces a pad-only block: word0 = 0x0100000000000000, word8 = 0x0000000000000080.
- Throughput: one word per cycle in FILL. Minimum gap between blocks is 1 ack cycle.

Optional Feature:
- Macro: KECCAK_SHA3_DOMAIN_EN.
- Defined: the first pad byte is 0x06 (FIPS-202 SHA-3 domain suffix) instead of 0x01. The same-byte collision case becomes 0x86.
- Undefined: original Keccak padding, first pad byte 0x01.
- All other behaviour is identical.

Test Plan:
- Empty message: after reset, in_last=1, in_bytes=0. Required: exactly one block, word0=0x0100000000000000, words1-7=0, word8=0x0000000000000080, out_last=1; out_valid rises 9 cycles after acceptance.
- 3-byte message: in_data=0xAABBCCxxxxxxxxxx, in_last=1, in_bytes=3. Required: word0=0xAABBCC0100000000, word8=0x80 in its low byte, out_last=1.
- Exact 72-byte message: 9 words 0x1111..1 to 0x9999..9 with in_last=0, then in_last=1, in_bytes=0. Required:
  - First block equals the words verbatim, out_last=0.
  - After out_ack, a second block that is pad-only, out_last=1.
- Collision: 8 full words, then a last word 0x0102030405060708 with in_bytes=7. Required: word8=0x0102030405060781; with KECCAK_SHA3_DOMAIN_EN, word8=0x0102030405060786.
- Backpressure: hold out_ack=0 for 5 cycles while in_valid=1 with new data. Required:
  - in_ready=0 throughout; out_block is unchanged.
  - No words are lost; the held word is accepted in the cycle after out_valid falls.
- Reset mid-fill: 4 words accepted, then reset=1 for 1 cycle. Required: out_valid=0, and the next 9 words form a block starting at word 0 with no residue from the earlier data.

Source files
------------

// File: rtl/keccak_word_packer.sv
// keccak_word_packer
//   Packs a 64-bit word stream into 576-bit Keccak rate blocks (9 words) and
//   applies pad10*1 on the final word of a message. A finished block is held
//   on out_block until out_ack. The word source is stalled while padding or
//   while a block is pending.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_data/in_valid/in_last/      word stream; in_bytes = valid bytes of the
//   in_bytes/in_ready              last word, byte 0 = in_data[63:56]
//   out_block/out_valid/out_last/  block handshake; word 0 = out_block[575:512]
//   out_ack
// Config macro:
//   KECCAK_SHA3_DOMAIN_EN  first pad byte 0x06 (SHA-3 suffix) instead of 0x01
module keccak_word_packer #(
  parameter int WORD_W     = 64,
  parameter int RATE_WORDS = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [2:0]                   in_bytes,
  output logic                         in_ready,
  output logic [WORD_W*RATE_WORDS-1:0] out_block,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ack
);
  localparam int BLK_W = WORD_W * RATE_WORDS;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [3:0] LAST_SLOT = 4'(RATE_WORDS - 1);

`ifdef KECCAK_SHA3_DOMAIN_EN
  localparam logic [7:0] PAD_FIRST = 8'h06;
`else
  localparam logic [7:0] PAD_FIRST = 8'h01;
`endif

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             pad_q, pad_d;

  logic [WORD_W-1:0] keep_mask, last_word, wr_word;
  logic [5:0]        bsh;
  int                slot_lo;

  // Final word: keep the top in_bytes bytes, place the first pad byte right
  // after them, zero the rest.
  assign bsh       = {in_bytes, 3'b000};
  assign keep_mask = ~({WORD_W{1'b1}} >> bsh);
  assign last_word = (in_data & keep_mask) | (WORD_W'(PAD_FIRST) << (6'd56 - bsh));

  // Slot n occupies out_block[575-64n -: 64].
  assign slot_lo = int'(LAST_SLOT - cnt_q) * WORD_W;

  assign in_ready  = (state_q == S_FILL);
  assign out_valid = (state_q == S_FULL);
  assign out_last  = out_valid & pad_q;
  assign out_block = blk_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    pad_d   = pad_q;
    wr_word = in_last ? last_word : in_data;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          blk_d[slot_lo +: WORD_W] = wr_word;
          cnt_d = cnt_q + 4'd1;
          if (in_last) pad_d = 1'b1;
          if (cnt_q == LAST_SLOT) begin
            // Last word in slot 8 closes the padding in the same cycle; with
            // in_bytes=7 both pad bytes share out_block[7:0].
            if (in_last) blk_d[7:0] = blk_d[7:0] | 8'h80;
            state_d = S_FULL;
          end else if (in_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        // Block was cleared when it started, so a zero word needs no write
        // other than the closing 0x80 on the last slot.
        blk_d[slot_lo +: WORD_W] = '0;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_SLOT) begin
          blk_d[7:0] = 8'h80;
          state_d    = S_FULL;
        end
      end
      S_FULL: begin
        if (out_ack) begin
          blk_d   = '0;
          cnt_d   = 4'd0;
          pad_d   = 1'b0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      cnt_q   <= 4'd0;
      blk_q   <= '0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      pad_q   <= pad_d;
    end
  end
endmodule

// File: tb/tb_keccak_word_packer.sv
module tb_keccak_word_packer;
  localparam int BW = 576;

`ifdef KECCAK_SHA3_DOMAIN_EN
  localparam logic [7:0] P1 = 8'h06;
`else
  localparam logic [7:0] P1 = 8'h01;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   in_data;
  logic          in_valid, in_last, in_ready, out_valid, out_last, out_ack;
  logic [2:0]    in_bytes;
  logic [BW-1:0] out_block;

  keccak_word_packer dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(in_ready),
    .out_block(out_block), .out_valid(out_valid), .out_last(out_last),
    .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] blk;
    logic          last;
    int            lat;   // cycles from last accepted word to out_valid, -1 = skip
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, ack_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one word and hold it until accepted (bounded).
  task automatic send(input logic [63:0] d, input logic l, input logic [2:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    else acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n < 300), 1);
  endtask

  // Scoreboard consumer: compares each presented block and acks it.
  initial begin
    exp_t          e;
    logic [BW-1:0] snap;
    out_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !reset) begin
        if (q.size() == 0) begin
          chk("unexpected_block", 1, 0);
        end else begin
          e = q.pop_front();
          chk("blk", out_block, e.blk);
          chk("last", out_last, e.last);
          if (e.lat >= 0) chk("latency", cyc - acc_cyc, e.lat);
        end
        snap = out_block;
        repeat (ack_delay) begin
          @(negedge clk);
          chk("bp_ready_low", in_ready, 0);
          chk("bp_hold", out_block, snap);
          chk("bp_valid", out_valid, 1);
        end
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("ack_valid_fall", out_valid, 0);
        chk("ack_ready", in_ready, 1);
      end
    end
  end

  initial begin
    exp_t        e;
    logic [63:0] w;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_bytes = 3'd0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_block", out_block, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    // Empty message -> pad-only block, 9 cycles after acceptance.
    e.blk = '0; e.blk[575:512] = {P1, 56'h0}; e.blk[63:0] = 64'h80; e.last = 1'b1; e.lat = 9;
    q.push_back(e);
    send(64'hDEAD_BEEF_0000_1234, 1'b1, 3'd0); idle(); drain();

    // 3-byte message.
    e.blk = '0; e.blk[575:512] = {24'hAABBCC, P1, 32'h0}; e.blk[63:0] = 64'h80; e.last = 1'b1; e.lat = 9;
    q.push_back(e);
    send(64'hAABBCC_77_66554433, 1'b1, 3'd3); idle(); drain();

    // Exact 72-byte message with backpressure on the first block; the
    // trailing in_last word is held by the source while the block is pending.
    ack_delay = 5;
    e.blk = '0; e.last = 1'b0; e.lat = 1;
    for (int i = 0; i < 9; i++) e.blk[575-64*i -: 64] = {16{4'(i+1)}};
    q.push_back(e);
    e.blk = '0; e.blk[575:512] = {P1, 56'h0}; e.blk[63:0] = 64'h80; e.last = 1'b1; e.lat = 9;
    q.push_back(e);
    for (int i = 0; i < 9; i++) send({16{4'(i+1)}}, 1'b0, 3'd0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0);
    idle(); drain();
    ack_delay = 0;

    // Collision: 8 full words then a 7-byte final word in slot 8.
    e.blk = '0; e.last = 1'b1; e.lat = 1;
    for (int i = 0; i < 8; i++) e.blk[575-64*i -: 64] = 64'hA5A5_0000_0000_0000 | 64'(i);
    e.blk[63:0] = {56'h01020304050607, P1 | 8'h80};
    q.push_back(e);
    for (int i = 0; i < 8; i++) send(64'hA5A5_0000_0000_0000 | 64'(i), 1'b0, 3'd0);
    send(64'h0102030405060708, 1'b1, 3'd7); idle(); drain();

    // Reset mid-fill: partial block is discarded.
    for (int i = 0; i < 4; i++) send(64'hBAD0_0000_0000_0000 | 64'(i), 1'b0, 3'd0);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_block", out_block, 0);
    chk("midrst_ready", in_ready, 1);
    e.blk = '0; e.last = 1'b0; e.lat = 1;
    for (int i = 0; i < 9; i++) begin
      w = {$urandom, $urandom};
      e.blk[575-64*i -: 64] = w;
    end
    q.push_back(e);
    for (int i = 0; i < 9; i++) send(e.blk[575-64*i -: 64], 1'b0, 3'd0);
    idle(); drain();

    repeat (5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    chk("end_valid", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1);
  end
endmodule
